seed_gen: RTL and testbench

Parametrised seed generator, successor to the 8-bit looping seed counter. A free-running basis register runs either as a wrapping up-counter or as a Galois LFSR. It is expanded into a wide seed by replicating {~basis, basis}. A valid/ready capture handshake delivers one frozen seed per request to the game FSM and pattern logic. Sits between the FSM signal bundle and the pattern generator; `seed_live` also exposes the unfrozen expansion.

---
 rtl/seed_pkg.sv | 18 +
 rtl/seed_expand.sv | 19 +
 rtl/seed_gen.sv | 111 +++++++++++
 tb/tb_seed_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared types and constants for the seed generator: basis stepping modes,
// handshake states and the default 8-bit Galois tap mask.
package seed_pkg;

  typedef enum logic {
    SEED_CNT  = 1'b0,
    SEED_LFSR = 1'b1
  } seed_mode_e;

  typedef enum logic {
    SEED_IDLE = 1'b0,
    SEED_HOLD = 1'b1
  } seed_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, maximal length (period 255) for 8 bits
  localparam logic [7:0] DEFAULT_TAPS8 = 8'hB8;

endpackage

// File: rtl/seed_expand.sv
// Expands a basis value into a wide seed by repeating {~basis, basis},
// most significant copy first.
module seed_expand #(
  parameter int BASIS_W = 8,
  parameter int SEED_W  = 32
) (
  input  logic [BASIS_W-1:0] basis_i,
  output logic [SEED_W-1:0]  seed_o
);

  localparam int REP = SEED_W / (2 * BASIS_W);

  if (BASIS_W < 2 || SEED_W <= 0 || (SEED_W % (2 * BASIS_W)) != 0) begin : g_bad_params
    $fatal(1, "seed_expand: SEED_W must be a nonzero multiple of 2*BASIS_W and BASIS_W >= 2");
  end

  assign seed_o = {REP{~basis_i, basis_i}};

endmodule

// File: rtl/seed_gen.sv
// Free-running basis register (wrapping counter or Galois LFSR) with a
// valid/ready capture handshake that freezes one expanded seed per request.
module seed_gen
  import seed_pkg::*;
#(
  parameter int                 BASIS_W   = 8,
  parameter int                 SEED_W    = 32,
  parameter logic [BASIS_W-1:0] LFSR_TAPS = BASIS_W'(DEFAULT_TAPS8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rst_seedgen,
  input  logic               mode,
  input  logic               load,
  input  logic [BASIS_W-1:0] load_val,
  input  logic               req,
  input  logic               seed_ready,
  output logic               seed_valid,
  output logic [SEED_W-1:0]  seed,
  output logic [SEED_W-1:0]  seed_live
);

  if (BASIS_W < 2 || SEED_W <= 0 || (SEED_W % (2 * BASIS_W)) != 0) begin : g_bad_params
    $fatal(1, "seed_gen: SEED_W must be a nonzero multiple of 2*BASIS_W and BASIS_W >= 2");
  end

  seed_mode_e         mode_e;
  logic [BASIS_W-1:0] basis_q, basis_d;
  logic [BASIS_W-1:0] lfsr_next;
  seed_state_e        state_q, state_d;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic [SEED_W-1:0]  seed_cap;

  assign mode_e = seed_mode_e'(mode);

  // An all-zero LFSR would lock up, so zero steps to 1.
  always_comb begin
    lfsr_next = (basis_q >> 1) ^ (basis_q[0] ? LFSR_TAPS : '0);
    if (basis_q == '0) begin
      lfsr_next = BASIS_W'(1);
    end
  end

  always_comb begin
    basis_d = basis_q;
    if (rst_seedgen) begin
      basis_d = '0;
    end else if (load) begin
      basis_d = load_val;
      if (mode_e == SEED_LFSR && load_val == '0) begin
        basis_d = BASIS_W'(1);
      end
    end else if (mode_e == SEED_LFSR) begin
      basis_d = lfsr_next;
    end else begin
      basis_d = basis_q + BASIS_W'(1);
    end
  end

  seed_expand #(.BASIS_W(BASIS_W), .SEED_W(SEED_W)) u_expand_cap (
    .basis_i (basis_q),
    .seed_o  (seed_cap)
  );

  seed_expand #(.BASIS_W(BASIS_W), .SEED_W(SEED_W)) u_expand_live (
    .basis_i (basis_q),
    .seed_o  (seed_live)
  );

  // Handshake: a seed transfers on a cycle where seed_valid && seed_ready.
  // While seed_valid is high and seed_ready is low, seed is held and req is
  // ignored. A transfer with req high recaptures in the same cycle.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    unique case (state_q)
      SEED_IDLE: begin
        if (req) begin
          seed_d  = seed_cap;
          state_d = SEED_HOLD;
        end
      end
      SEED_HOLD: begin
        if (seed_ready) begin
          if (req) begin
            seed_d = seed_cap;
          end else begin
            state_d = SEED_IDLE;
          end
        end
      end
      default: state_d = SEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      basis_q <= '0;
      state_q <= SEED_IDLE;
      seed_q  <= '0;
    end else begin
      basis_q <= basis_d;
      state_q <= state_d;
      seed_q  <= seed_d;
    end
  end

  assign seed_valid = (state_q == SEED_HOLD);
  assign seed       = seed_q;

endmodule

// File: tb/tb_seed_gen.sv
// Self-checking bench for seed_gen: directed scenarios with literal
// expectations plus a randomized phase checked against a behavioural model.
module tb_seed_gen;

  localparam int BASIS_W = 8;
  localparam int SEED_W  = 32;
  localparam logic [7:0] TAPS = 8'hB8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               rst_seedgen = 1'b0;
  logic               mode = 1'b0;
  logic               load = 1'b0;
  logic [BASIS_W-1:0] load_val = '0;
  logic               req = 1'b0;
  logic               seed_ready = 1'b0;
  logic               seed_valid;
  logic [SEED_W-1:0]  seed;
  logic [SEED_W-1:0]  seed_live;

  seed_gen #(.BASIS_W(BASIS_W), .SEED_W(SEED_W), .LFSR_TAPS(TAPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .rst_seedgen (rst_seedgen),
    .mode        (mode),
    .load        (load),
    .load_val    (load_val),
    .req         (req),
    .seed_ready  (seed_ready),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .seed_live   (seed_live)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [SEED_W-1:0] act,
                       input logic [SEED_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SEED_W-1:0] expand(input int b);
    logic [SEED_W-1:0] r;
    int lo;
    int hi;
    lo = b % 256;
    hi = 255 - lo;
    r = '0;
    for (int i = 0; i < SEED_W / 16; i++) begin
      r = (r << 16) | SEED_W'(hi * 256 + lo);
    end
    return r;
  endfunction

  // behavioural model: basis as an integer, seed buffer as a value + flag
  int                m_basis = 0;
  logic              m_valid = 1'b0;
  logic [SEED_W-1:0] m_seed = '0;

  function automatic int model_step(input int b, input logic lfsr);
    if (!lfsr) return (b + 1) % 256;
    if (b == 0) return 1;
    return (b / 2) ^ ((b % 2 == 1) ? int'(TAPS) : 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_basis <= 0;
      m_valid <= 1'b0;
      m_seed  <= '0;
    end else begin
      if (!m_valid || seed_ready) begin
        if (req) begin
          m_seed  <= expand(m_basis);
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (rst_seedgen)                      m_basis <= 0;
      else if (load && mode && load_val == 0) m_basis <= 1;
      else if (load)                        m_basis <= int'(load_val);
      else                                  m_basis <= model_step(m_basis, mode);
    end
  end

  // compare process
  always @(negedge clk) begin
    check("cyc_valid", SEED_W'(seed_valid), SEED_W'(m_valid));
    check("cyc_seed", seed, m_seed);
    check("cyc_live", seed_live, expand(m_basis));
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [SEED_W-1:0] exp_hold;
  int zero_seen;

  initial begin
    #2;
    check("rst_valid", SEED_W'(seed_valid), 32'h0);
    check("rst_seed", seed, 32'h0);
    check("rst_live", seed_live, 32'hFF00FF00);

    // counter from reset: capture when basis is 02
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    check("cnt_live02", seed_live, 32'hFD02FD02);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    check("cnt_valid", SEED_W'(seed_valid), 32'h1);
    check("cnt_seed", seed, 32'hFD02FD02);
    seed_ready = 1'b1;
    cyc(1);
    seed_ready = 1'b0;
    check("cnt_release", SEED_W'(seed_valid), 32'h0);
    check("cnt_keep", seed, 32'hFD02FD02);

    // counter wrap
    load = 1'b1;
    load_val = 8'hFE;
    cyc(1);
    load = 1'b0;
    check("wrap_fe", seed_live, 32'h01FE01FE);
    cyc(1);
    check("wrap_ff", seed_live, 32'h00FF00FF);
    cyc(1);
    check("wrap_00", seed_live, 32'hFF00FF00);

    // LFSR stepping and period
    mode = 1'b1;
    load = 1'b1;
    load_val = 8'h00;
    cyc(1);
    load = 1'b0;
    check("lfsr_01", seed_live, 32'hFE01FE01);
    cyc(1);
    check("lfsr_b8", seed_live, 32'h47B847B8);
    cyc(1);
    check("lfsr_5c", seed_live, 32'hA35CA35C);
    zero_seen = 0;
    for (int i = 0; i < 253; i++) begin
      cyc(1);
      if (seed_live[7:0] == 8'h00) zero_seen++;
    end
    check("lfsr_period", seed_live, 32'hFE01FE01);
    check("lfsr_nozero", SEED_W'(zero_seen), 32'h0);

    // backpressure: toggling req while not ready must not disturb seed
    cyc(3);
    exp_hold = expand(m_basis);
    req = 1'b1;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      req = i[0];
      check("bp_seed", seed, exp_hold);
      check("bp_valid", SEED_W'(seed_valid), 32'h1);
      cyc(1);
    end
    seed_ready = 1'b1;
    req = 1'b1;
    exp_hold = expand(m_basis);
    cyc(1);
    seed_ready = 1'b0;
    req = 1'b0;
    check("b2b_seed", seed, exp_hold);
    check("b2b_valid", SEED_W'(seed_valid), 32'h1);

    // priority: clear beats load, held seed untouched
    rst_seedgen = 1'b1;
    load = 1'b1;
    load_val = 8'h55;
    cyc(1);
    rst_seedgen = 1'b0;
    load = 1'b0;
    check("prio_live", seed_live, 32'hFF00FF00);
    check("prio_seed", seed, exp_hold);
    check("prio_valid", SEED_W'(seed_valid), 32'h1);

    // async reset while holding
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", SEED_W'(seed_valid), 32'h0);
    check("arst_seed", seed, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_basis0", seed_live, 32'hFF00FF00);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      req         = ($urandom_range(0, 1) == 1);
      seed_ready  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      load        = ($urandom_range(0, 15) == 0);
      load_val    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rst_seedgen = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
